eeg_wram_rd_sched: RTL and testbench

Read-job scheduler for the weight RAM. It accepts one read job at a time: a command (WTOA or READ), a bank mask, a base address and a length. It then issues the matching configuration command to the WRAM and drives per-bank address streams on the WRAM address port. It monitors the WRAM data-return port and signals completion once every selected bank has returned its last datum.

---
 rtl/eeg_wram_rd_sched_if.sv | 46 ++++
 rtl/eeg_wram_rd_sched.sv | 113 +++++++++++
 tb/tb_eeg_wram_rd_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_wram_rd_sched_if.sv
// Job, WRAM configuration, per-bank address and monitored data-return signals of the WRAM read scheduler.
// The master modport is the scheduler side. The slave modport is the job source plus the WRAM.
interface eeg_wram_rd_sched_if #(
   parameter int WRAM_CMD_DW = 6,
   parameter int WRAM_NUM_DW = 4,
   parameter int WRAM_ADD_AW = 13
);
   logic                                      JOB_VLD;
   logic                                      JOB_RDY;
   logic [WRAM_CMD_DW-1:0]                    JOB_CMD;
   logic [WRAM_NUM_DW-1:0]                    JOB_IDX;
   logic [WRAM_ADD_AW-1:0]                    JOB_BASE;
   logic [WRAM_ADD_AW-1:0]                    JOB_LEN;
   logic                                      JOB_DONE;
   logic                                      JOB_ERR;
   logic                                      IS_IDLE;
   logic                                      CFG_INFO_VLD;
   logic                                      CFG_INFO_RDY;
   logic [WRAM_CMD_DW-1:0]                    CFG_INFO_CMD;
   logic [WRAM_NUM_DW-1:0]                    CFG_WRAM_IDX;
   logic [WRAM_NUM_DW-1:0]                    ETOW_ADD_VLD;
   logic [WRAM_NUM_DW-1:0]                    ETOW_ADD_LST;
   logic [WRAM_NUM_DW-1:0]                    ETOW_ADD_RDY;
   logic [WRAM_NUM_DW-1:0][WRAM_ADD_AW-1:0]   ETOW_ADD_ADD;
   logic [WRAM_NUM_DW-1:0]                    WTOE_DAT_VLD;
   logic [WRAM_NUM_DW-1:0]                    WTOE_DAT_LST;
   logic [WRAM_NUM_DW-1:0]                    WTOE_DAT_RDY;

   modport master (
      input  JOB_VLD, JOB_CMD, JOB_IDX, JOB_BASE, JOB_LEN,
      input  CFG_INFO_RDY, ETOW_ADD_RDY,
      input  WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_RDY,
      output JOB_RDY, JOB_DONE, JOB_ERR, IS_IDLE,
      output CFG_INFO_VLD, CFG_INFO_CMD, CFG_WRAM_IDX,
      output ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD
   );

   modport slave (
      output JOB_VLD, JOB_CMD, JOB_IDX, JOB_BASE, JOB_LEN,
      output CFG_INFO_RDY, ETOW_ADD_RDY,
      output WTOE_DAT_VLD, WTOE_DAT_LST, WTOE_DAT_RDY,
      input  JOB_RDY, JOB_DONE, JOB_ERR, IS_IDLE,
      input  CFG_INFO_VLD, CFG_INFO_CMD, CFG_WRAM_IDX,
      input  ETOW_ADD_VLD, ETOW_ADD_LST, ETOW_ADD_ADD
   );
endinterface

// File: rtl/eeg_wram_rd_sched.sv
// WRAM read-job scheduler: one job at a time, CFG one cycle after accept, then per-bank address streams.
// A stalled bank holds only its own stream; completion waits on the monitored last-data of every selected bank.
module eeg_wram_rd_sched #(
   parameter int WRAM_CMD_DW = 6,
   parameter int WRAM_NUM_DW = 4,
   parameter int WRAM_ADD_AW = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   eeg_wram_rd_sched_if.master     io_sch
);

   localparam logic [WRAM_CMD_DW-1:0] CMD_WTOA = WRAM_CMD_DW'(16);
   localparam logic [WRAM_CMD_DW-1:0] CMD_READ = WRAM_CMD_DW'(32);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_ADDR, S_WAIT, S_DONE} state_t;

   state_t                                    r_state;
   state_t                                    w_state_nxt;
   logic [WRAM_CMD_DW-1:0]                    r_cmd;
   logic [WRAM_NUM_DW-1:0]                    r_idx;
   logic [WRAM_ADD_AW-1:0]                    r_base;
   logic [WRAM_ADD_AW-1:0]                    r_len;
   logic [WRAM_NUM_DW-1:0][WRAM_ADD_AW-1:0]   r_cnt;
   logic [WRAM_NUM_DW-1:0]                    r_addr_done;
   logic [WRAM_NUM_DW-1:0]                    r_dat_done;
   logic                                      r_err;

   logic                                      w_job_hs;
   logic                                      w_job_ok;
   logic [WRAM_NUM_DW-1:0]                    w_add_vld;
   logic [WRAM_NUM_DW-1:0]                    w_add_lst;
   logic [WRAM_NUM_DW-1:0][WRAM_ADD_AW-1:0]   w_add_add;
   logic [WRAM_NUM_DW-1:0]                    w_dat_lst;

   assign w_job_hs  = io_sch.JOB_VLD & (r_state == S_IDLE);
   assign w_job_ok  = ((io_sch.JOB_CMD == CMD_WTOA) || (io_sch.JOB_CMD == CMD_READ)) && (|io_sch.JOB_IDX);
   // Unselected banks have addr_done preset, so they never raise VLD.
   assign w_add_vld = (r_state == S_ADDR) ? ~r_addr_done : '0;
   assign w_dat_lst = io_sch.WTOE_DAT_VLD & io_sch.WTOE_DAT_RDY & io_sch.WTOE_DAT_LST & r_idx;

   always_comb begin
      w_add_add = '0;
      w_add_lst = '0;
      for (int b = 0; b < WRAM_NUM_DW; b++) begin
         w_add_add[b] = r_base + r_cnt[b];
         w_add_lst[b] = w_add_vld[b] & (r_cnt[b] == r_len);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_job_hs && w_job_ok)  w_state_nxt = S_CFG;
         S_CFG:   if (io_sch.CFG_INFO_RDY)   w_state_nxt = S_ADDR;
         S_ADDR:  if (&r_addr_done)          w_state_nxt = S_WAIT;
         S_WAIT:  if (&r_dat_done)           w_state_nxt = S_DONE;
         S_DONE:                             w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd       <= '0;
         r_idx       <= '0;
         r_base      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_addr_done <= '0;
         r_dat_done  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_job_hs & ~w_job_ok;
         if (w_job_hs) begin
            r_cmd       <= io_sch.JOB_CMD;
            r_idx       <= io_sch.JOB_IDX;
            r_base      <= io_sch.JOB_BASE;
            r_len       <= io_sch.JOB_LEN;
            r_cnt       <= '0;
            r_addr_done <= ~io_sch.JOB_IDX;
            r_dat_done  <= ~io_sch.JOB_IDX;
         end else begin
            for (int b = 0; b < WRAM_NUM_DW; b++) begin
               if (w_add_vld[b] && io_sch.ETOW_ADD_RDY[b]) begin
                  r_cnt[b] <= r_cnt[b] + WRAM_ADD_AW'(1);
                  if (w_add_lst[b]) r_addr_done[b] <= 1'b1;
               end
            end
            // Data can overtake the last address, so returns are watched from ADDR onward.
            if ((r_state == S_ADDR) || (r_state == S_WAIT))
               r_dat_done <= r_dat_done | w_dat_lst;
         end
      end
   end

   assign io_sch.JOB_RDY      = (r_state == S_IDLE);
   assign io_sch.IS_IDLE      = (r_state == S_IDLE);
   assign io_sch.JOB_DONE     = (r_state == S_DONE);
   assign io_sch.JOB_ERR      = r_err;
   assign io_sch.CFG_INFO_VLD = (r_state == S_CFG);
   assign io_sch.CFG_INFO_CMD = r_cmd;
   assign io_sch.CFG_WRAM_IDX = r_idx;
   assign io_sch.ETOW_ADD_VLD = w_add_vld;
   assign io_sch.ETOW_ADD_LST = w_add_lst;
   assign io_sch.ETOW_ADD_ADD = w_add_add;

endmodule

// File: tb/tb_eeg_wram_rd_sched.sv
// Bench for eeg_wram_rd_sched: directed jobs, expectations queued at issue, checked by a negedge monitor.
// A small WRAM model returns each address as data two cycles after its handshake.
module tb_eeg_wram_rd_sched;
   localparam int CDW = 6;
   localparam int NB  = 4;
   localparam int AW  = 13;
   localparam logic [CDW-1:0] WTOA = 6'b010000;
   localparam logic [CDW-1:0] READ = 6'b100000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eeg_wram_rd_sched_if #(.WRAM_CMD_DW(CDW), .WRAM_NUM_DW(NB), .WRAM_ADD_AW(AW)) bus ();

   eeg_wram_rd_sched #(.WRAM_CMD_DW(CDW), .WRAM_NUM_DW(NB), .WRAM_ADD_AW(AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_sch (bus)
   );

   typedef struct packed {logic lst; logic [AW-1:0] add;} add_exp_t;

   int                   n_chk = 0;
   int                   n_fail = 0;
   add_exp_t             q_add [NB][$];
   logic [CDW+NB-1:0]    q_cfg [$];
   int                   q_evt [$];
   logic [NB-1:0]        rdy_base;
   logic                 rnd_en;
   logic                 rnd_bit;
   logic [NB-1:0]        prev_stall;
   logic [AW-1:0]        prev_add [NB];
   logic [NB-1:0]        p0v, p0l, p1v, p1l;

   assign bus.ETOW_ADD_RDY = {rdy_base[3:2], (rnd_en ? rnd_bit : rdy_base[1]), rdy_base[0]};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: output seen with nothing expected", name);
   endtask

   // Monitor: pops the expectation queue whenever the DUT presents a handshake or pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (prev_stall[b]) begin
               check($sformatf("hold_vld_b%0d", b), 64'(bus.ETOW_ADD_VLD[b]), 64'd1);
               check($sformatf("hold_add_b%0d", b), 64'(bus.ETOW_ADD_ADD[b]), 64'(prev_add[b]));
            end
            if (bus.ETOW_ADD_VLD[b] && bus.ETOW_ADD_RDY[b]) begin
               if (q_add[b].size() == 0) miss($sformatf("addr_b%0d", b));
               else begin
                  add_exp_t e;
                  e = q_add[b].pop_front();
                  check($sformatf("addr_b%0d", b), 64'(bus.ETOW_ADD_ADD[b]), 64'(e.add));
                  check($sformatf("lst_b%0d", b), 64'(bus.ETOW_ADD_LST[b]), 64'(e.lst));
               end
            end
            prev_stall[b] = bus.ETOW_ADD_VLD[b] & ~bus.ETOW_ADD_RDY[b];
            prev_add[b]   = bus.ETOW_ADD_ADD[b];
         end
         if (bus.CFG_INFO_VLD && bus.CFG_INFO_RDY) begin
            if (q_cfg.size() == 0) miss("cfg");
            else check("cfg_cmd_idx", 64'({bus.CFG_INFO_CMD, bus.CFG_WRAM_IDX}), 64'(q_cfg.pop_front()));
         end
         if (bus.JOB_DONE) begin
            if (q_evt.size() == 0) miss("job_done");
            else check("job_done", 64'd1, 64'(q_evt.pop_front()));
         end
         if (bus.JOB_ERR) begin
            if (q_evt.size() == 0) miss("job_err");
            else check("job_err", 64'd2, 64'(q_evt.pop_front()));
         end
      end
   end

   // WRAM model: data last returns two cycles after the address handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         p0v = '0; p0l = '0; p1v = '0; p1l = '0;
         bus.WTOE_DAT_VLD = '0;
         bus.WTOE_DAT_LST = '0;
      end else begin
         bus.WTOE_DAT_VLD = p1v;
         bus.WTOE_DAT_LST = p1l;
         p1v = p0v;
         p1l = p0l;
         p0v = bus.ETOW_ADD_VLD & bus.ETOW_ADD_RDY;
         p0l = bus.ETOW_ADD_VLD & bus.ETOW_ADD_RDY & bus.ETOW_ADD_LST;
      end
   end

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic push_one(input int b, input logic [AW-1:0] add, input logic lst);
      add_exp_t e;
      e.add = add;
      e.lst = lst;
      q_add[b].push_back(e);
   endtask

   task automatic push_seq(input logic [NB-1:0] idx, input logic [AW-1:0] base, input int len);
      for (int b = 0; b < NB; b++)
         if (idx[b])
            for (int i = 0; i <= len; i++) push_one(b, base + AW'(i), (i == len));
   endtask

   function automatic logic queues_empty();
      logic r;
      r = (q_cfg.size() == 0) && (q_evt.size() == 0);
      for (int b = 0; b < NB; b++) r = r && (q_add[b].size() == 0);
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_job_rdy"},  64'(bus.JOB_RDY), 64'd1);
      check({tag, "_is_idle"},  64'(bus.IS_IDLE), 64'd1);
      check({tag, "_job_done"}, 64'(bus.JOB_DONE), 64'd0);
      check({tag, "_job_err"},  64'(bus.JOB_ERR), 64'd0);
      check({tag, "_cfg_vld"},  64'(bus.CFG_INFO_VLD), 64'd0);
      check({tag, "_cfg_cmd"},  64'(bus.CFG_INFO_CMD), 64'd0);
      check({tag, "_cfg_idx"},  64'(bus.CFG_WRAM_IDX), 64'd0);
      check({tag, "_add_vld"},  64'(bus.ETOW_ADD_VLD), 64'd0);
      check({tag, "_add_lst"},  64'(bus.ETOW_ADD_LST), 64'd0);
      check({tag, "_add_add"},  64'(bus.ETOW_ADD_ADD), 64'd0);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      @(negedge clk); #1;
      while (!(bus.JOB_RDY && queues_empty()) && k < 500) begin
         @(negedge clk); #1;
         k++;
      end
      if (k >= 500) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: job not finished after %0d cycles", tag, k);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic issue(input logic [CDW-1:0] cmd, input logic [NB-1:0] idx,
                        input logic [AW-1:0] base, input logic [AW-1:0] len);
      @(posedge clk); #1;
      bus.JOB_VLD  = 1'b1;
      bus.JOB_CMD  = cmd;
      bus.JOB_IDX  = idx;
      bus.JOB_BASE = base;
      bus.JOB_LEN  = len;
      @(negedge clk);
      check("job_rdy_at_accept", 64'(bus.JOB_RDY), 64'd1);
      @(posedge clk); #1;
      bus.JOB_VLD = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [CDW-1:0] cmd, input logic [NB-1:0] idx,
                          input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic ok, input int cfg_stall);
      if (ok) begin
         q_cfg.push_back({cmd, idx});
         q_evt.push_back(1);
      end else begin
         q_evt.push_back(2);
      end
      bus.CFG_INFO_RDY = (cfg_stall == 0);
      issue(cmd, idx, base, len);
      @(negedge clk);
      if (ok) begin
         check({tag, "_cfg_vld_t1"}, 64'(bus.CFG_INFO_VLD), 64'd1);
      end else begin
         check({tag, "_err_rdy_t1"}, 64'(bus.JOB_RDY), 64'd1);
         check({tag, "_no_cfg_t1"}, 64'(bus.CFG_INFO_VLD), 64'd0);
      end
      if (cfg_stall > 0) begin
         for (int i = 1; i < cfg_stall; i++) begin
            @(negedge clk);
            check({tag, "_cfg_hold"}, 64'(bus.CFG_INFO_VLD), 64'd1);
         end
         @(posedge clk); #1;
         bus.CFG_INFO_RDY = 1'b1;
      end
      wait_idle(tag);
   endtask

   initial begin
      bus.JOB_VLD      = 1'b0;
      bus.JOB_CMD      = '0;
      bus.JOB_IDX      = '0;
      bus.JOB_BASE     = '0;
      bus.JOB_LEN      = '0;
      bus.CFG_INFO_RDY = 1'b1;
      bus.WTOE_DAT_RDY = '1;
      rdy_base         = '1;
      rnd_en           = 1'b0;
      #1;
      check_reset_vals("rst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int b = 0; b < NB; b++) begin
         push_one(b, 13'd16, 1'b0);
         push_one(b, 13'd17, 1'b0);
         push_one(b, 13'd18, 1'b0);
         push_one(b, 13'd19, 1'b1);
      end
      run_job("read4", READ, 4'b1111, 13'd16, 13'd3, 1'b1, 0);

      push_one(0, 13'd100, 1'b1);
      push_one(2, 13'd100, 1'b1);
      run_job("wtoa_len0", WTOA, 4'b0101, 13'd100, 13'd0, 1'b1, 0);

      rnd_en = 1'b1;
      for (int b = 0; b < NB; b++) begin
         push_one(b, 13'd16, 1'b0);
         push_one(b, 13'd17, 1'b0);
         push_one(b, 13'd18, 1'b0);
         push_one(b, 13'd19, 1'b1);
      end
      run_job("bp", READ, 4'b1111, 13'd16, 13'd3, 1'b1, 5);
      rnd_en = 1'b0;

      push_one(0, 13'd8190, 1'b0); push_one(0, 13'd8191, 1'b0);
      push_one(0, 13'd0, 1'b0);    push_one(0, 13'd1, 1'b1);
      push_one(3, 13'd8190, 1'b0); push_one(3, 13'd8191, 1'b0);
      push_one(3, 13'd0, 1'b0);    push_one(3, 13'd1, 1'b1);
      run_job("wrap", READ, 4'b1001, 13'd8190, 13'd3, 1'b1, 0);

      run_job("bad_cmd", 6'b000100, 4'b1111, 13'd0, 13'd0, 1'b0, 0);
      run_job("bad_idx", READ, 4'b0000, 13'd0, 13'd0, 1'b0, 0);

      // Reset in the middle of an 8-address stream, right after the second address.
      push_seq(4'b1111, 13'd0, 7);
      q_cfg.push_back({READ, 4'b1111});
      q_evt.push_back(1);
      issue(READ, 4'b1111, 13'd0, 13'd7);
      for (int k = 0; k < 100 && q_add[0].size() > 6; k++) begin
         @(negedge clk); #1;
      end
      check("mid_reset_progress", 64'(q_add[0].size()), 64'd6);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      for (int b = 0; b < NB; b++) q_add[b].delete();
      q_cfg.delete();
      q_evt.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_seq(4'b0011, 13'd5, 1);
      run_job("after_rst", READ, 4'b0011, 13'd5, 13'd1, 1'b1, 0);

      repeat (5) @(posedge clk);
      check("end_cfg_q", 64'(q_cfg.size()), 64'd0);
      check("end_evt_q", 64'(q_evt.size()), 64'd0);
      check("end_idle", 64'(bus.JOB_RDY), 64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
